// File: rtl/test_finish_monitor.sv
// test_finish_monitor
//   Watches the harness memory write path for the tohost word and turns
//   it into a test verdict. Writes to other addresses are accepted and
//   dropped. A tohost write with device byte 8'h01 in data[63:56] is a
//   console character carried in data[7:0]. Any other tohost write with
//   data[0]==1 is an exit request whose code is data[63:1]: zero means
//   pass, nonzero means fail. All other tohost writes are ignored.
//
//   Optional build macro: WATCHDOG_EN. When defined, an idle-cycle
//   watchdog forces a failure (exit code all-ones, io_timeout=1) after
//   WATCHDOG_CYCLES RUN cycles without an accepted write. When undefined,
//   there is no counter and io_timeout is tied to 0.
//
// Parameters
//   TOHOST_ADDR      word address of the tohost register
//   WATCHDOG_CYCLES  idle-cycle limit (WATCHDOG_EN builds only)
//
// Ports
//   clock, reset     single clock, asynchronous active-high reset
//   io_req_*         write request (valid/ready, 32-bit addr, 64-bit data)
//   io_putc_*        one-entry console byte stream (valid/ready, 8-bit)
//   io_success       test passed (terminal until reset)
//   io_failure       test failed (terminal until reset)
//   io_exit_code     nonzero exit code on failure, all-ones on timeout
//   io_timeout       failure caused by the watchdog
module test_finish_monitor #(
    parameter logic [31:0] TOHOST_ADDR     = 32'h8000_1000,
    parameter int unsigned WATCHDOG_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [31:0] io_req_addr,
    input  logic [63:0] io_req_data,
    output logic        io_putc_valid,
    input  logic        io_putc_ready,
    output logic [7:0]  io_putc_bits,
    output logic        io_success,
    output logic        io_failure,
    output logic [62:0] io_exit_code,
    output logic        io_timeout
);

    localparam logic [7:0]  DEV_CONSOLE = 8'h01;
    localparam logic [31:0] WD_LAST     = 32'(WATCHDOG_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} state_t;

    state_t      state;
    logic [62:0] pend_code;
    logic        accept;
    logic        to_host;
    logic        is_console;
    logic        is_exit;
    logic        putc_fire;
    logic        exit_stalled;
    logic        finish_now;
    logic        wd_expire;
    logic [62:0] fin_code;

    // New requests are only taken while running and while the console
    // buffer has room (empty, or emptying this cycle).
    assign io_req_ready = !reset && (state == RUN) && (!io_putc_valid || io_putc_ready);
    assign accept       = io_req_valid && io_req_ready;
    assign to_host      = accept && (io_req_addr == TOHOST_ADDR);

    // Console writes carry the character in the low byte, so bit 0 belongs
    // to the character there and must not be read as an exit flag.
    assign is_console   = to_host && (io_req_data[63:56] == DEV_CONSOLE);
    assign is_exit      = to_host && io_req_data[0] && (io_req_data[63:56] != DEV_CONSOLE);

    assign putc_fire    = io_putc_valid && io_putc_ready;
    assign exit_stalled = io_putc_valid && !io_putc_ready;

    // An exit completes immediately unless a console byte is still stuck
    // in the buffer; in that case DRAIN holds the code until it leaves.
    assign finish_now   = ((state == RUN) && is_exit && !exit_stalled) ||
                          ((state == DRAIN) && putc_fire);
    assign fin_code     = (state == DRAIN) ? pend_code : io_req_data[63:1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            pend_code     <= '0;
            io_success    <= 1'b0;
            io_failure    <= 1'b0;
            io_exit_code  <= '0;
            io_putc_valid <= 1'b0;
            io_putc_bits  <= '0;
        end else begin
            // A refill in the same cycle as a drain keeps the buffer full.
            if (is_console) begin
                io_putc_valid <= 1'b1;
                io_putc_bits  <= io_req_data[7:0];
            end else if (putc_fire) begin
                io_putc_valid <= 1'b0;
            end

            if (finish_now) begin
                if (fin_code == '0) begin
                    state      <= PASS;
                    io_success <= 1'b1;
                end else begin
                    state        <= FAIL;
                    io_failure   <= 1'b1;
                    io_exit_code <= fin_code;
                end
            end else if ((state == RUN) && is_exit) begin
                state     <= DRAIN;
                pend_code <= io_req_data[63:1];
            end else if (wd_expire) begin
                state        <= FAIL;
                io_failure   <= 1'b1;
                io_exit_code <= '1;
            end
        end
    end

`ifdef WATCHDOG_EN
    logic [31:0] wd_count;

    // An accepted write in the expiry cycle wins: it clears the counter.
    assign wd_expire = (state == RUN) && !accept && (wd_count >= WD_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_count <= '0;
        end else if ((state != RUN) || accept) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_timeout <= 1'b0;
        end else if (wd_expire) begin
            io_timeout <= 1'b1;
        end
    end
`else
    logic unused_wd_cfg;
    assign unused_wd_cfg = ^WD_LAST;
    assign wd_expire     = 1'b0;
    assign io_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_test_finish_monitor.sv
// Self-checking bench for test_finish_monitor: directed scenarios followed
// by randomized traffic, all compared against a transaction-level model.
module tb_test_finish_monitor;

    localparam logic [31:0] TOHOST   = 32'h8000_1000;
    localparam logic [31:0] OTHER    = 32'h8000_2000;
    localparam int          WD       = 16;
    localparam logic [62:0] ALL_ONES = {63{1'b1}};
`ifdef WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        putc_valid;
    logic        putc_ready = 1'b0;
    logic [7:0]  putc_bits;
    logic        success;
    logic        failure;
    logic [62:0] exit_code;
    logic        timeout;

    always #5 clock = ~clock;

    test_finish_monitor #(
        .TOHOST_ADDR     (TOHOST),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (req_valid),
        .io_req_ready  (req_ready),
        .io_req_addr   (req_addr),
        .io_req_data   (req_data),
        .io_putc_valid (putc_valid),
        .io_putc_ready (putc_ready),
        .io_putc_bits  (putc_bits),
        .io_success    (success),
        .io_failure    (failure),
        .io_exit_code  (exit_code),
        .io_timeout    (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: verdict, pending exit, console byte, idle count.
    bit          m_done;
    bit          m_pass;
    bit          m_drain;
    bit          m_tmo;
    bit          m_pv;
    logic [62:0] m_code;
    logic [7:0]  m_pb;
    int          m_idle;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        m_done = 0; m_pass = 0; m_drain = 0; m_tmo = 0; m_pv = 0;
        m_code = '0; m_pb = '0; m_idle = 0;
    endfunction

    function automatic void model_finish(input logic [62:0] c);
        m_done  = 1;
        m_drain = 0;
        m_pass  = (c == '0);
        m_code  = c;
    endfunction

    task automatic check_outputs();
        check("success",    success,    m_done && m_pass);
        check("failure",    failure,    m_done && !m_pass);
        check("timeout",    timeout,    m_tmo);
        check("exit_code",  exit_code,  (m_done && !m_pass) ? (m_tmo ? ALL_ONES : m_code) : 63'd0);
        check("putc_valid", putc_valid, m_pv);
        check("putc_bits",  putc_bits,  m_pb);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] a, input logic [63:0] d, input bit pr);
        bit exp_ready;
        bit fire;
        bit fire_putc;
        bit host;
        bit console;
        req_valid  = v;
        req_addr   = a;
        req_data   = d;
        putc_ready = pr;
        #1;
        exp_ready = !m_done && !m_drain && (!m_pv || pr);
        check("req_ready", req_ready, exp_ready);
        fire      = v && exp_ready;
        fire_putc = m_pv && pr;
        host      = fire && (a == TOHOST);
        console   = host && (d[63:56] == 8'h01);
        if (m_drain && fire_putc) begin
            model_finish(m_code);
        end else if (host && d[0] && !console) begin
            if (m_pv && !pr) begin
                m_drain = 1;
                m_code  = d[63:1];
            end else begin
                model_finish(d[63:1]);
            end
        end else if (WD_EN && !m_done && !m_drain) begin
            if (fire) m_idle = 0;
            else if (m_idle + 1 >= WD) begin
                m_done = 1; m_pass = 0; m_tmo = 1;
            end else m_idle++;
        end
        if (console) begin
            m_pv = 1;
            m_pb = d[7:0];
        end else if (fire_putc) begin
            m_pv = 0;
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    // Asserted at a falling edge; outputs must clear without a clock edge.
    task automatic apply_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        putc_ready = 1'b0;
        #1;
        check("rst_ready",      req_ready,  1'b0);
        check("rst_success",    success,    1'b0);
        check("rst_failure",    failure,    1'b0);
        check("rst_timeout",    timeout,    1'b0);
        check("rst_exit_code",  exit_code,  63'd0);
        check("rst_putc_valid", putc_valid, 1'b0);
        check("rst_putc_bits",  putc_bits,  8'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    function automatic logic [63:0] rand_data();
        logic [63:0] d;
        int k;
        d = {$urandom(), $urandom()};
        k = $urandom_range(0, 39);
        if (k == 0) d = 64'h1;
        else if (k == 1) begin
            d[63:56] = 8'h00;
            d[0]     = 1'b1;
        end else if (k < 20) d[63:56] = 8'h01;
        else begin
            d[0] = 1'b0;
            if (d[63:56] == 8'h01) d[63:56] = 8'h00;
        end
        return d;
    endfunction

    initial begin
        model_clear();
        @(negedge clock);

        // Pass exit, verdict held, no further requests accepted.
        apply_reset();
        cycle(1, TOHOST, 64'h1, 1);
        check("pass_success", success, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1, OTHER, 64'h0, 1);
        check("pass_held", success, 1'b1);
        check("pass_ready_low", req_ready, 1'b0);

        // Fail exit with code 3.
        apply_reset();
        cycle(1, TOHOST, 64'h7, 1);
        check("fail_flag", failure, 1'b1);
        check("fail_code", exit_code, 63'd3);
        check("fail_no_success", success, 1'b0);

        // Console byte stalled for five cycles, exit waits behind it.
        apply_reset();
        cycle(1, TOHOST, 64'h0100_0000_0000_0041, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, TOHOST, 64'h1, 0);
            check("stall_bits", putc_bits, 8'h41);
            check("stall_no_success", success, 1'b0);
        end
        cycle(1, TOHOST, 64'h1, 1);
        check("drain_success", success, 1'b1);
        check("drain_empty", putc_valid, 1'b0);

        // Drain and refill in one cycle keeps the new byte valid.
        apply_reset();
        cycle(1, TOHOST, 64'h0100_0000_0000_0042, 0);
        cycle(1, TOHOST, 64'h0100_0000_0000_0043, 1);
        check("refill_valid", putc_valid, 1'b1);
        check("refill_bits", putc_bits, 8'h43);

        // Reset mid-operation drops the buffered byte.
        cycle(0, 32'h0, 64'h0, 0);
        apply_reset();

        // Idle watchdog.
        for (int i = 0; i < 20; i++) cycle(0, 32'h0, 64'h0, 1);
        check("wd_idle_timeout", timeout, WD_EN);
        check("wd_idle_failure", failure, WD_EN);
        check("wd_idle_code", exit_code, WD_EN ? ALL_ONES : 63'd0);

        // Periodic writes keep the watchdog quiet.
        apply_reset();
        for (int i = 0; i < 60; i++) cycle(i % 10 == 0, OTHER, 64'h5, 1);
        check("wd_kept_timeout", timeout, 1'b0);
        check("wd_kept_failure", failure, 1'b0);

        // Non-tohost exit pattern is swallowed; reset after pass.
        apply_reset();
        cycle(1, OTHER, 64'h1, 1);
        check("other_no_pass", success, 1'b0);
        check("other_no_fail", failure, 1'b0);
        cycle(1, TOHOST, 64'h1, 1);
        check("then_pass", success, 1'b1);
        apply_reset();

        // Randomized traffic.
        for (int ep = 0; ep < 6; ep++) begin
            apply_reset();
            for (int i = 0; i < 120; i++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 3) != 0) ? TOHOST : $urandom();
                cycle($urandom_range(0, 1) == 1, a, rand_data(), $urandom_range(0, 1) == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
